// File: rtl/ncc_search_pkg.sv
// Shared types and helpers for the NCC search engine: FSM states, accumulator
// sizing and row-bus pixel extraction.
package ncc_search_pkg;

  typedef enum logic [1:0] {
    DESC_LOAD,
    SCAN,
    COMPARE,
    DONE
  } ncc_state_t;

  // Upper bounds for the generic pixel slicer; callers zero-extend into these.
  localparam int MAX_ROW_W = 4096;
  localparam int MAX_PIX_W = 32;

  // Wide enough that a full-scale patch sum of products cannot overflow.
  function automatic int acc_width(input int pix_w, input int dim);
    return 2 * pix_w + 2 * $clog2(dim);
  endfunction

  function automatic logic [MAX_PIX_W-1:0] unpack_pix(input logic [MAX_ROW_W-1:0] row,
                                                      input int idx, input int pix_w);
    logic [MAX_PIX_W-1:0] mask;
    mask = (MAX_PIX_W'(1) << pix_w) - MAX_PIX_W'(1);
    return MAX_PIX_W'(row >> (idx * pix_w)) & mask;
  endfunction

endpackage

// File: rtl/ncc_search_engine_row_mac.sv
// Combinational row MAC: dot product of a descriptor row with a window row and
// the window row's sum of squares.
module ncc_row_mac
  import ncc_search_pkg::*;
#(
  parameter int PATCH_DIM = 16,
  parameter int PIX_W     = 8,
  parameter int ACC_W     = acc_width(PIX_W, PATCH_DIM)
) (
  input  logic [PATCH_DIM*PIX_W-1:0] d_row,
  input  logic [PATCH_DIM*PIX_W-1:0] w_row,
  output logic [ACC_W-1:0]           dot,
  output logic [ACC_W-1:0]           sq
);

  logic [PIX_W-1:0] d_pix;
  logic [PIX_W-1:0] w_pix;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dot   = '0;
    sq    = '0;
    d_pix = '0;
    w_pix = '0;
    for (int j = 0; j < PATCH_DIM; j++) begin
      d_pix = PIX_W'(unpack_pix(MAX_ROW_W'(d_row), j, PIX_W));
      w_pix = PIX_W'(unpack_pix(MAX_ROW_W'(w_row), j, PIX_W));
      dot   = dot + ACC_W'(d_pix) * ACC_W'(w_pix);
      sq    = sq + ACC_W'(w_pix) * ACC_W'(w_pix);
    end
  end

endmodule

// File: rtl/ncc_search_engine.sv
// Exact integer NCC search: loads one descriptor patch, scans NUM_WINDOWS
// windows row by row and keeps the window maximising num^2/wsq.
module ncc_search_engine
  import ncc_search_pkg::*;
#(
  parameter int  PATCH_DIM   = 16,
  parameter int  PIX_W       = 8,
  parameter int  NUM_WINDOWS = 150,
  localparam int ACC_W       = acc_width(PIX_W, PATCH_DIM),
  localparam int IDX_W       = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       desc_valid,
  output logic                       desc_ready,
  input  logic [PATCH_DIM*PIX_W-1:0] desc_row,
  input  logic                       win_valid,
  output logic                       win_ready,
  input  logic [PATCH_DIM*PIX_W-1:0] win_row,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [ACC_W-1:0]           best_num,
  output logic [ACC_W-1:0]           best_wsq,
  output logic [ACC_W-1:0]           desc_sq,
  output logic [IDX_W-1:0]           best_index
);

  localparam int ROW_W  = PATCH_DIM * PIX_W;
  localparam int RC_W   = (PATCH_DIM > 1) ? $clog2(PATCH_DIM) : 1;
  localparam int PROD_W = 3 * ACC_W;
  localparam logic [RC_W-1:0]  LAST_ROW = RC_W'(PATCH_DIM - 1);
  localparam logic [IDX_W-1:0] LAST_WIN = IDX_W'(NUM_WINDOWS - 1);

  ncc_state_t       state_q, state_d;
  logic [RC_W-1:0]  row_cnt_q, row_cnt_d;
  logic [IDX_W-1:0] win_cnt_q, win_cnt_d;
  logic [IDX_W-1:0] best_index_q, best_index_d;
  logic [ACC_W-1:0] num_acc_q, num_acc_d;
  logic [ACC_W-1:0] wsq_acc_q, wsq_acc_d;
  logic [ACC_W-1:0] desc_sq_q, desc_sq_d;
  logic [ACC_W-1:0] best_num_q, best_num_d;
  logic [ACC_W-1:0] best_wsq_q, best_wsq_d;
  logic             best_seen_q, best_seen_d;

  logic [ROW_W-1:0]  row_buf [PATCH_DIM];
  logic [ROW_W-1:0]  mac_w_row;
  logic [ACC_W-1:0]  row_dot, row_sq;
  logic [PROD_W-1:0] cand_score, best_score;
  logic              desc_fire, win_fire, last_row, replace;

  assign desc_fire = desc_valid & desc_ready;
  assign win_fire  = win_valid & win_ready;
  assign last_row  = (row_cnt_q == LAST_ROW);

  // During descriptor load the window port of the MAC squares the incoming row.
  assign mac_w_row = (state_q == DESC_LOAD) ? desc_row : win_row;

  ncc_row_mac #(
    .PATCH_DIM(PATCH_DIM),
    .PIX_W    (PIX_W),
    .ACC_W    (ACC_W)
  ) u_row_mac (
    .d_row(row_buf[row_cnt_q]),
    .w_row(mac_w_row),
    .dot  (row_dot),
    .sq   (row_sq)
  );

  // Cross-multiplied ratio test: num_c^2/wsq_c > num_b^2/wsq_b.
  assign cand_score = PROD_W'(num_acc_q) * PROD_W'(num_acc_q) * PROD_W'(best_wsq_q);
  assign best_score = PROD_W'(best_num_q) * PROD_W'(best_num_q) * PROD_W'(wsq_acc_q);
  assign replace    = !best_seen_q || ((wsq_acc_q != '0) && (cand_score > best_score));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) state_q <= DESC_LOAD;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DESC_LOAD: if (desc_fire && last_row) state_d = SCAN;
      SCAN:      if (win_fire && last_row)  state_d = COMPARE;
      COMPARE:   state_d = (win_cnt_q == LAST_WIN) ? DONE : SCAN;
      DONE:      if (result_ready) state_d = DESC_LOAD;
      default:   state_d = DESC_LOAD;
    endcase
  end

  always_comb begin
    desc_ready   = (state_q == DESC_LOAD);
    win_ready    = (state_q == SCAN);
    result_valid = (state_q == DONE);
  end

  always_comb begin
    row_cnt_d    = row_cnt_q;
    win_cnt_d    = win_cnt_q;
    num_acc_d    = num_acc_q;
    wsq_acc_d    = wsq_acc_q;
    desc_sq_d    = desc_sq_q;
    best_num_d   = best_num_q;
    best_wsq_d   = best_wsq_q;
    best_index_d = best_index_q;
    best_seen_d  = best_seen_q;
    case (state_q)
      DESC_LOAD: if (desc_fire) begin
        desc_sq_d = desc_sq_q + row_sq;
        row_cnt_d = last_row ? '0 : row_cnt_q + RC_W'(1);
      end
      SCAN: if (win_fire) begin
        num_acc_d = num_acc_q + row_dot;
        wsq_acc_d = wsq_acc_q + row_sq;
        row_cnt_d = last_row ? '0 : row_cnt_q + RC_W'(1);
      end
      COMPARE: begin
        if (replace) begin
          best_num_d   = num_acc_q;
          best_wsq_d   = wsq_acc_q;
          best_index_d = win_cnt_q;
          best_seen_d  = 1'b1;
        end
        num_acc_d = '0;
        wsq_acc_d = '0;
        win_cnt_d = win_cnt_q + IDX_W'(1);
      end
      DONE: if (result_ready) begin
        row_cnt_d    = '0;
        win_cnt_d    = '0;
        desc_sq_d    = '0;
        best_num_d   = '0;
        best_wsq_d   = '0;
        best_index_d = '0;
        best_seen_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row_cnt_q    <= '0;
      win_cnt_q    <= '0;
      num_acc_q    <= '0;
      wsq_acc_q    <= '0;
      desc_sq_q    <= '0;
      best_num_q   <= '0;
      best_wsq_q   <= '0;
      best_index_q <= '0;
      best_seen_q  <= 1'b0;
    end else begin
      row_cnt_q    <= row_cnt_d;
      win_cnt_q    <= win_cnt_d;
      num_acc_q    <= num_acc_d;
      wsq_acc_q    <= wsq_acc_d;
      desc_sq_q    <= desc_sq_d;
      best_num_q   <= best_num_d;
      best_wsq_q   <= best_wsq_d;
      best_index_q <= best_index_d;
      best_seen_q  <= best_seen_d;
    end
  end

  // NOTE: the row buffer has no reset; every descriptor load overwrites it
  // before it is read, so resetting it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst && !clr && desc_fire) row_buf[row_cnt_q] <= desc_row;
  end

  assign best_num   = best_num_q;
  assign best_wsq   = best_wsq_q;
  assign desc_sq    = desc_sq_q;
  assign best_index = best_index_q;

endmodule

// File: tb/tb_ncc_search_engine.sv
// Directed bench: 2x2 patches over three windows on the main instance, plus a
// full-scale 16x16 single-window instance for accumulator headroom.
module tb_ncc_search_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        desc_valid = 1'b0, win_valid = 1'b0, result_ready = 1'b0;
  logic        desc_ready, win_ready, result_valid;
  logic [15:0] desc_row = '0, win_row = '0;
  logic [17:0] best_num, best_wsq, desc_sq;
  logic [1:0]  best_index;

  logic         clr_f = 1'b0;
  logic         desc_valid_f = 1'b0, win_valid_f = 1'b0, result_ready_f = 1'b0;
  logic         desc_ready_f, win_ready_f, result_valid_f;
  logic [127:0] desc_row_f = '0, win_row_f = '0;
  logic [23:0]  best_num_f, best_wsq_f, desc_sq_f;
  logic [0:0]   best_index_f;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ncc_search_engine #(.PATCH_DIM(2), .PIX_W(8), .NUM_WINDOWS(3)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_row(desc_row),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row),
    .result_valid(result_valid), .result_ready(result_ready),
    .best_num(best_num), .best_wsq(best_wsq), .desc_sq(desc_sq), .best_index(best_index)
  );

  ncc_search_engine #(.PATCH_DIM(16), .PIX_W(8), .NUM_WINDOWS(1)) dut_full (
    .clk(clk), .rst(rst), .clr(clr_f),
    .desc_valid(desc_valid_f), .desc_ready(desc_ready_f), .desc_row(desc_row_f),
    .win_valid(win_valid_f), .win_ready(win_ready_f), .win_row(win_row_f),
    .result_valid(result_valid_f), .result_ready(result_ready_f),
    .best_num(best_num_f), .best_wsq(best_wsq_f), .desc_sq(desc_sq_f), .best_index(best_index_f)
  );

  // Offers one row and returns one step after the edge that accepted it.
  task automatic push_row(input bit is_win, input logic [15:0] row, input int bubbles);
    bit done = 1'b0;
    int guard = 0;
    repeat (bubbles) begin @(posedge clk); #1; end
    if (is_win) begin win_row = row; win_valid = 1'b1; end
    else begin desc_row = row; desc_valid = 1'b1; end
    while (!done) begin
      @(negedge clk);
      if (is_win ? win_ready : desc_ready) done = 1'b1;
      @(posedge clk); #1;
      if (!done) begin
        guard++;
        if (guard > 100) begin
          vectors++; miscompares++;
          $display("FAIL handshake_timeout is_win=%0d row=%h", is_win, row);
          done = 1'b1;
        end
      end
    end
    win_valid = 1'b0;
    desc_valid = 1'b0;
  endtask

  task automatic load_desc(input int bmax);
    push_row(1'b0, {8'd2, 8'd1}, $urandom_range(0, bmax));
    push_row(1'b0, {8'd4, 8'd3}, $urandom_range(0, bmax));
  endtask

  task automatic push_window(input logic [7:0] a, b, c, d, input int bmax);
    push_row(1'b1, {b, a}, $urandom_range(0, bmax));
    push_row(1'b1, {d, c}, $urandom_range(0, bmax));
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if ({result_valid, best_index, best_num, best_wsq, desc_sq} !== 57'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h exp 0", {result_valid, best_index, best_num, best_wsq, desc_sq});
    end
    vectors++;
    if ({desc_ready, win_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_ready got %b exp 10", {desc_ready, win_ready});
    end
  endtask

  task automatic test_desc_load();
    push_row(1'b0, {8'd2, 8'd1}, 0);
    vectors++;
    if ({desc_ready, desc_sq} !== {1'b1, 18'd5}) begin
      miscompares++;
      $display("FAIL desc_row0 got ready=%b sq=%0d exp ready=1 sq=5", desc_ready, desc_sq);
    end
    push_row(1'b0, {8'd4, 8'd3}, 0);
    vectors++;
    if ({desc_ready, win_ready, desc_sq} !== {2'b01, 18'd30}) begin
      miscompares++;
      $display("FAIL desc_done got dr=%b wr=%b sq=%0d exp dr=0 wr=1 sq=30", desc_ready, win_ready, desc_sq);
    end
  endtask

  // Descriptor already loaded by test_desc_load; windows 0 and 1 tie.
  task automatic test_tie();
    push_window(8'd1, 8'd2, 8'd3, 8'd4, 0);
    @(posedge clk); #1;
    vectors++;
    if ({result_valid, best_index, best_num, best_wsq} !== {1'b0, 2'd0, 18'd30, 18'd30}) begin
      miscompares++;
      $display("FAIL tie_first got idx=%0d num=%0d wsq=%0d exp idx=0 num=30 wsq=30", best_index, best_num, best_wsq);
    end
    push_window(8'd2, 8'd4, 8'd6, 8'd8, 0);
    push_window(8'd4, 8'd3, 8'd2, 8'd1, 0);
    vectors++;
    if (result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_t1_valid got %b exp 0", result_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if ({result_valid, best_index, best_num, best_wsq, desc_sq} !== {1'b1, 2'd0, 18'd30, 18'd30, 18'd30}) begin
      miscompares++;
      $display("FAIL tie_result got v=%b idx=%0d num=%0d wsq=%0d dsq=%0d exp v=1 idx=0 num=30 wsq=30 dsq=30",
               result_valid, best_index, best_num, best_wsq, desc_sq);
    end
    release_result();
    vectors++;
    if ({desc_ready, win_ready, result_valid, best_index, best_num, best_wsq, desc_sq} !== {3'b100, 56'd0}) begin
      miscompares++;
      $display("FAIL tie_release got dr=%b v=%b num=%0d dsq=%0d exp dr=1 v=0 all 0", desc_ready, result_valid, best_num, desc_sq);
    end
  endtask

  task automatic test_zero_window();
    load_desc(0);
    push_window(8'd4, 8'd3, 8'd2, 8'd1, 0);
    @(posedge clk); #1;
    vectors++;
    if ({best_index, best_num, best_wsq} !== {2'd0, 18'd20, 18'd30}) begin
      miscompares++;
      $display("FAIL zero_first got idx=%0d num=%0d wsq=%0d exp idx=0 num=20 wsq=30", best_index, best_num, best_wsq);
    end
    push_window(8'd1, 8'd2, 8'd3, 8'd4, 0);
    @(posedge clk); #1;
    vectors++;
    if ({best_index, best_num, best_wsq} !== {2'd1, 18'd30, 18'd30}) begin
      miscompares++;
      $display("FAIL zero_replace got idx=%0d num=%0d wsq=%0d exp idx=1 num=30 wsq=30", best_index, best_num, best_wsq);
    end
    push_window(8'd0, 8'd0, 8'd0, 8'd0, 0);
    @(posedge clk); #1;
    vectors++;
    if ({result_valid, best_index, best_num, best_wsq, desc_sq} !== {1'b1, 2'd1, 18'd30, 18'd30, 18'd30}) begin
      miscompares++;
      $display("FAIL zero_result got v=%b idx=%0d num=%0d wsq=%0d dsq=%0d exp v=1 idx=1 num=30 wsq=30 dsq=30",
               result_valid, best_index, best_num, best_wsq, desc_sq);
    end
    release_result();
  endtask

  task automatic test_stalls();
    load_desc(3);
    push_window(8'd1, 8'd2, 8'd3, 8'd4, 3);
    push_window(8'd2, 8'd4, 8'd6, 8'd8, 3);
    push_window(8'd4, 8'd3, 8'd2, 8'd1, 3);
    vectors++;
    if (result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_t1_valid got %b exp 0", result_valid);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({result_valid, desc_ready, win_ready, best_index, best_num, best_wsq, desc_sq} !==
          {3'b100, 2'd0, 18'd30, 18'd30, 18'd30}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got v=%b idx=%0d num=%0d wsq=%0d dsq=%0d exp v=1 idx=0 num=30 wsq=30 dsq=30",
                 i, result_valid, best_index, best_num, best_wsq, desc_sq);
      end
      @(posedge clk); #1;
    end
    release_result();
    vectors++;
    if ({desc_ready, result_valid, best_num, desc_sq} !== {2'b10, 36'd0}) begin
      miscompares++;
      $display("FAIL stall_release got dr=%b v=%b num=%0d dsq=%0d exp dr=1 v=0 0 0", desc_ready, result_valid, best_num, desc_sq);
    end
  endtask

  task automatic test_clr();
    load_desc(0);
    push_window(8'd1, 8'd2, 8'd3, 8'd4, 0);
    push_row(1'b1, {8'd4, 8'd2}, 0);
    vectors++;
    if (best_num !== 18'd30) begin
      miscompares++;
      $display("FAIL clr_pre got num=%0d exp 30", best_num);
    end
    clr = 1'b1;
    win_row = {8'd8, 8'd6};
    win_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    win_valid = 1'b0;
    vectors++;
    if ({desc_ready, win_ready, result_valid, best_index, best_num, best_wsq, desc_sq} !== {3'b100, 56'd0}) begin
      miscompares++;
      $display("FAIL clr_state got dr=%b wr=%b v=%b idx=%0d num=%0d wsq=%0d dsq=%0d exp dr=1 all 0",
               desc_ready, win_ready, result_valid, best_index, best_num, best_wsq, desc_sq);
    end
    load_desc(1);
    push_window(8'd1, 8'd2, 8'd3, 8'd4, 1);
    push_window(8'd2, 8'd4, 8'd6, 8'd8, 1);
    push_window(8'd4, 8'd3, 8'd2, 8'd1, 1);
    @(posedge clk); #1;
    vectors++;
    if ({result_valid, best_index, best_num, best_wsq, desc_sq} !== {1'b1, 2'd0, 18'd30, 18'd30, 18'd30}) begin
      miscompares++;
      $display("FAIL clr_reload got v=%b idx=%0d num=%0d wsq=%0d dsq=%0d exp v=1 idx=0 num=30 wsq=30 dsq=30",
               result_valid, best_index, best_num, best_wsq, desc_sq);
    end
    release_result();
  endtask

  task automatic test_full_scale();
    desc_row_f = '1;
    desc_valid_f = 1'b1;
    repeat (16) @(posedge clk);
    #1 desc_valid_f = 1'b0;
    vectors++;
    if ({win_ready_f, desc_sq_f} !== {1'b1, 24'd16646400}) begin
      miscompares++;
      $display("FAIL full_desc got wr=%b dsq=%0d exp wr=1 dsq=16646400", win_ready_f, desc_sq_f);
    end
    win_row_f = '1;
    win_valid_f = 1'b1;
    repeat (16) @(posedge clk);
    #1 win_valid_f = 1'b0;
    vectors++;
    if (result_valid_f !== 1'b0) begin
      miscompares++;
      $display("FAIL full_t1_valid got %b exp 0", result_valid_f);
    end
    @(posedge clk); #1;
    vectors++;
    if ({result_valid_f, best_index_f, best_num_f, best_wsq_f, desc_sq_f} !==
        {1'b1, 1'b0, 24'd16646400, 24'd16646400, 24'd16646400}) begin
      miscompares++;
      $display("FAIL full_result got v=%b idx=%0d num=%0d wsq=%0d dsq=%0d exp v=1 idx=0 all 16646400",
               result_valid_f, best_index_f, best_num_f, best_wsq_f, desc_sq_f);
    end
    result_ready_f = 1'b1;
    @(posedge clk); #1;
    result_ready_f = 1'b0;
  endtask

  initial begin
    test_reset();
    test_desc_load();
    test_tie();
    test_zero_window();
    test_stalls();
    test_clr();
    test_full_scale();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ncc_search_engine.md
Name: ncc_search_engine

Overview:
- Parametrised successor to the 16x16 log-domain NCC array.
- Exact integer normalised cross-correlation between one stored descriptor patch and a stream of NUM_WINDOWS candidate windows.
- Descriptor and window data arrive one patch row per beat over valid/ready handshakes.
- Reports the best window by the ratio num^2/wsq without division or sqrt; descriptor sum of squares is a common factor and is reported separately.
- Sits between the frame-buffer window fetcher and the match-result collector.

Parameters:
PATCH_DIM, 16, patch edge length in pixels; one row = PATCH_DIM pixels.
PIX_W, 8, unsigned pixel width.
NUM_WINDOWS, 150, windows scanned per descriptor (>=1).
ACC_W, 2*PIX_W+2*$clog2(PATCH_DIM), derived accumulator width; not overridable.
IDX_W, $clog2(NUM_WINDOWS) (min 1), derived window-index width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clr  in  1  synchronous abort; same effect as rst on state, counters and outputs
desc_valid  in  1  descriptor row valid
desc_ready  out  1  engine accepts descriptor row
desc_row  in  PATCH_DIM*PIX_W  descriptor row, pixel 0 in LSBs
win_valid  in  1  window row valid
win_ready  out  1  engine accepts window row
win_row  in  PATCH_DIM*PIX_W  window row, pixel 0 in LSBs
result_valid  out  1  best result stable
result_ready  in  1  consumer accepts result
best_num  out  ACC_W  sum(d*w) of best window
best_wsq  out  ACC_W  sum(w^2) of best window
desc_sq  out  ACC_W  sum(d^2) of descriptor
best_index  out  IDX_W  index of best window (0-based, arrival order)

Behaviour:
- States: DESC_LOAD, SCAN, COMPARE, DONE. Reset/clr -> DESC_LOAD; all counters, accumulators and outputs = 0; best_seen = 0.
- Transfer occurs on valid & ready in the same cycle.
- DESC_LOAD:
  - desc_ready = 1, win_ready = 0.
  - Each accepted row is written to row buffer [row_cnt], and desc_sq += sum of the row's d^2.
  - After the PATCH_DIM-th accepted row: go to SCAN, row_cnt = 0.
- SCAN:
  - win_ready = 1, desc_ready = 0.
  - Each accepted row r: num_acc += sum_j d[r][j]*w[j]; wsq_acc += sum_j w[j]^2.
  - Row arithmetic is combinational within the accepting cycle; the accumulator is registered.
  - After the PATCH_DIM-th row: go to COMPARE.
- COMPARE (exactly 1 cycle; win_ready = 0):
  - Candidate (num_acc, wsq_acc) replaces best if best_seen = 0, or if num_acc^2 * best_wsq > best_num^2 * wsq_acc.
  - Comparison uses full 3*ACC_W-bit unsigned products.
  - Strict greater-than: on a tie the earlier window is kept.
  - If best_seen = 1 and wsq_acc = 0, the candidate never replaces best.
  - On replacement: best_index <= win_cnt.
  - Accumulators are cleared; win_cnt increments.
  - If win_cnt == NUM_WINDOWS-1: go to DONE; otherwise return to SCAN.
- Latency: the last row of a window is accepted at cycle t; the best_* update is visible at t+2. After the final window, result_valid = 1 from t+2.
- DONE:
  - result_valid = 1; best_*, desc_sq and best_index are held stable; both ready outputs = 0.
  - On result_ready, go to DESC_LOAD in the next cycle and clear all outputs, accumulators and counters.
- Row buffer is not cleared by reset; it is overwritten by each descriptor load.
- Input behaviour:
  - Backpressure: valid with ready = 0 is held by the source; no data is dropped.
  - Bubbles (valid = 0) are allowed anywhere.
  - clr has priority over every other event, including a simultaneous handshake.
- Widths: ACC_W is sized so that a full-scale patch (all pixels 2^PIX_W-1) never overflows num_acc, wsq_acc or desc_sq; the bench checks this at full scale.

Decomposition:
- Package ncc_search_pkg:
  - state enum ncc_state_t {DESC_LOAD, SCAN, COMPARE, DONE};
  - function acc_width(pix_w, dim);
  - pixel-unpack function slicing a row bus into PIX_W fields.
- Sub-module ncc_row_mac (combinational): PATCH_DIM descriptor pixels + PATCH_DIM window pixels -> row dot product and row window sum of squares; instantiated once, with the window inputs reused during descriptor load to form d^2.

Test Plan:
- Bench configuration: PATCH_DIM=2, PIX_W=8, NUM_WINDOWS=3, giving ACC_W=18 and IDX_W=2 (the derived default).
- Descriptor rows [1,2],[3,4] -> desc_sq=30 after 2 accepted rows; desc_ready drops, win_ready rises the next cycle.
- Windows [1,2;3,4], [2,4;6,8], [4,3;2,1] -> scores 30, 30 (tie), 13.3 -> best_index=0, best_num=30, best_wsq=30, result_valid at t+2 after the last row.
- Windows [4,3;2,1], [1,2;3,4], [0,0;0,0] -> best_index=1, best_num=30, best_wsq=30; the zero window does not replace best.
- Random valid/ready stalls on every handshake, including holding result_ready=0 for 10 cycles -> results identical to the stall-free run; outputs stable throughout DONE.
- clr asserted mid-window (after 1 row of window 1) -> all outputs 0, state DESC_LOAD next cycle; a full reload then reproduces the expected results.
- Full-scale test: all pixels 255 in both patches, NUM_WINDOWS=1, default PATCH_DIM=16 -> best_num = best_wsq = desc_sq = 16646400 with no overflow.
